// File: rtl/nco_mc_pkg.sv
// nco_mc_pkg: shared quadrant type, LFSR constants, LUT and channel-width functions for nco_mc
package nco_mc_pkg;
   typedef enum logic [1:0] {Q0, Q1, Q2, Q3} quad_t;
   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   // right-shift Fibonacci form of taps 16,14,13,11: feedback = b0^b2^b3^b5
   localparam logic [15:0] LFSR_TAPS = 16'h002D;
   localparam real PI = 3.14159265358979323846;
   function automatic int chw_f(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
   // half-sample offset keeps every quarter-wave entry strictly positive
   function automatic int lut_entry(input int i, input int mpr, input int aw);
      real v;
      v = (2.0 ** (mpr - 1) - 1.0) * $sin(2.0 * PI * ($itor(i) + 0.5) / (2.0 ** (aw + 2)));
      return $rtoi(v + 0.5);
   endfunction
endpackage

// File: rtl/nco_mc_qlut.sv
// nco_mc_qlut: dual-read quarter-wave LUT (stage 2) and quadrant fold to sin/cos (stage 3)
// Ports: clk, reset_n (async active-low), clken; i_phase = truncated phase {quadrant, address};
//        o_sin/o_cos = registered signed samples, two clken edges after i_phase.
module nco_mc_qlut
   import nco_mc_pkg::*;
#(
   parameter int MPR    = 16,
   parameter int LUT_AW = 8
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     clken,
   input  logic [LUT_AW+1:0]        i_phase,
   output logic signed [MPR-1:0]    o_sin,
   output logic signed [MPR-1:0]    o_cos
);
   logic signed [MPR-1:0] w_rom [2**LUT_AW];
   logic [LUT_AW-1:0] w_a;
   logic signed [MPR-1:0] r_la, r_lna;
   quad_t r_q;
   for (genvar i = 0; i < 2**LUT_AW; i++) begin : g_rom
      localparam logic signed [MPR-1:0] L = MPR'(lut_entry(i, MPR, LUT_AW));
      assign w_rom[i] = L;
   end
   assign w_a = i_phase[LUT_AW-1:0];
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         r_la  <= '0;
         r_lna <= '0;
         r_q   <= Q0;
         o_sin <= '0;
         o_cos <= '0;
      end else if (clken) begin
         r_la  <= w_rom[w_a];
         r_lna <= w_rom[~w_a];
         r_q   <= quad_t'(i_phase[LUT_AW+1 -: 2]);
         o_sin <= (r_q == Q0) ? r_la  : (r_q == Q1) ? r_lna : (r_q == Q2) ? -r_la  : -r_lna;
         o_cos <= (r_q == Q0) ? r_lna : (r_q == Q1) ? -r_la : (r_q == Q2) ? -r_lna : r_la;
      end
endmodule

// File: rtl/nco_mc.sv
// nco_mc: time-multiplexed multi-channel quadrature NCO, one channel per enabled cycle
// Ports: clk, reset_n (async active-low), clken (global enable), sync_i (clear all accumulators),
//        cfg_we/cfg_ch/cfg_phi_inc/cfg_phase_ofs (per-channel config write, independent of clken),
//        fsin_o/fcos_o (signed samples), out_ch (sample channel), out_valid (pipeline filled).
// Option: define NCO_MC_DITHER_EN to add LFSR phase dither below the truncation point.
module nco_mc
   import nco_mc_pkg::*;
#(
   parameter int NCH      = 4,
   parameter int APR      = 32,
   parameter int MPR      = 16,
   parameter int LUT_AW   = 8,
   parameter int DITHER_W = 4,
   localparam int CHW     = chw_f(NCH)
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  clken,
   input  logic                  sync_i,
   input  logic                  cfg_we,
   input  logic [CHW-1:0]        cfg_ch,
   input  logic [APR-1:0]        cfg_phi_inc,
   input  logic [APR-1:0]        cfg_phase_ofs,
   output logic signed [MPR-1:0] fsin_o,
   output logic signed [MPR-1:0] fcos_o,
   output logic [CHW-1:0]        out_ch,
   output logic                  out_valid
);
   localparam int PW = LUT_AW + 2;
   logic [APR-1:0] r_acc [NCH];
   logic [APR-1:0] r_inc [NCH];
   logic [APR-1:0] r_ofs [NCH];
   logic [CHW-1:0] r_cnt, r_ch1, r_ch2;
   logic [PW-1:0] r_p1;
   logic [2:0] r_vld;
   logic [APR-1:0] w_dith, w_sum;
`ifdef NCO_MC_DITHER_EN
   logic [15:0] r_lfsr;
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) r_lfsr <= LFSR_SEED;
      else if (clken) r_lfsr <= {^(r_lfsr & LFSR_TAPS), r_lfsr[15:1]};
   assign w_dith = APR'(r_lfsr[DITHER_W-1:0]) << (APR - PW - DITHER_W);
`else
   assign w_dith = APR'({DITHER_W{1'b0}});
`endif
   assign w_sum = r_acc[r_cnt] + r_ofs[r_cnt] + w_dith;
   assign out_valid = r_vld[2];
   // config writes ignore clken; a same-edge visit still reads the old values
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         for (int n = 0; n < NCH; n++) begin
            r_inc[n] <= '0;
            r_ofs[n] <= '0;
         end
      end else if (cfg_we) begin
         r_inc[cfg_ch] <= cfg_phi_inc;
         r_ofs[cfg_ch] <= cfg_phase_ofs;
      end
   // stage 1 keeps running on a sync edge so in-flight samples drain untouched
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         for (int n = 0; n < NCH; n++) r_acc[n] <= '0;
         r_cnt  <= '0;
         r_p1   <= '0;
         r_ch1  <= '0;
         r_ch2  <= '0;
         out_ch <= '0;
         r_vld  <= '0;
      end else if (clken) begin
         r_p1   <= PW'(w_sum >> (APR - PW));
         r_ch1  <= r_cnt;
         r_ch2  <= r_ch1;
         out_ch <= r_ch2;
         r_vld  <= {r_vld[1:0], 1'b1};
         r_cnt  <= (sync_i || r_cnt == CHW'(NCH - 1)) ? '0 : r_cnt + CHW'(1);
         if (sync_i)
            for (int n = 0; n < NCH; n++) r_acc[n] <= '0;
         else
            r_acc[r_cnt] <= r_acc[r_cnt] + r_inc[r_cnt];
      end
   nco_mc_qlut #(.MPR(MPR), .LUT_AW(LUT_AW)) u_qlut (
      .clk     (clk),
      .reset_n (reset_n),
      .clken   (clken),
      .i_phase (r_p1),
      .o_sin   (fsin_o),
      .o_cos   (fcos_o)
   );
endmodule

// File: tb/tb_nco_mc.sv
// tb_nco_mc: directed self-checking bench for nco_mc with default parameters
module tb_nco_mc;
   logic clk = 1'b0, reset_n = 1'b0, clken = 1'b0, sync_i = 1'b0, cfg_we = 1'b0;
   logic [1:0] cfg_ch = '0;
   logic [31:0] cfg_phi_inc = '0, cfg_phase_ofs = '0;
   logic signed [15:0] fsin_o, fcos_o;
   logic [1:0] out_ch;
   logic out_valid;
   int n_chk = 0, n_pass = 0, e = 0;
   localparam logic [31:0] QT = 32'h4000_0000, HT = 32'h8000_0000;
   int sq [4] = '{101, 32767, -101, -32767};
   int cq [4] = '{32767, -101, -32767, 101};
   always #5 clk = ~clk;
   nco_mc dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .clken         (clken),
      .sync_i        (sync_i),
      .cfg_we        (cfg_we),
      .cfg_ch        (cfg_ch),
      .cfg_phi_inc   (cfg_phi_inc),
      .cfg_phase_ofs (cfg_phase_ofs),
      .fsin_o        (fsin_o),
      .fcos_o        (fcos_o),
      .out_ch        (out_ch),
      .out_valid     (out_valid)
   );
   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
   endtask
   task automatic chk_out(input string tag, input int ch, input int s, input int c);
      chk({tag, ".valid"}, int'(out_valid), 1);
      chk({tag, ".ch"}, int'(out_ch), ch);
      chk({tag, ".sin"}, int'(fsin_o), s);
      chk({tag, ".cos"}, int'(fcos_o), c);
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
      if (clken) e++;
   endtask
   task automatic rst_dut(input string tag);
      reset_n = 1'b0;
      clken = 1'b0;
      sync_i = 1'b0;
      cfg_we = 1'b0;
      #1;
      chk({tag, ".rst_valid"}, int'(out_valid), 0);
      chk({tag, ".rst_ch"}, int'(out_ch), 0);
      chk({tag, ".rst_sin"}, int'(fsin_o), 0);
      chk({tag, ".rst_cos"}, int'(fcos_o), 0);
      @(negedge clk);
      reset_n = 1'b1;
      e = 0;
   endtask
   task automatic cfg(input int ch, input logic [31:0] inc, input logic [31:0] ofs);
      cfg_we = 1'b1;
      cfg_ch = 2'(ch);
      cfg_phi_inc = inc;
      cfg_phase_ofs = ofs;
      tick();
      cfg_we = 1'b0;
   endtask
   initial begin
      // all-zero config: constant phase 0 on every channel
      rst_dut("A");
      clken = 1'b1;
      tick();
      tick();
      chk("A.valid_e2", int'(out_valid), 0);
      for (int k = 3; k <= 10; k++) begin
         tick();
         chk_out($sformatf("A.e%0d", e), (e - 3) % 4, 101, 32767);
      end
      // quarter-turn offset on ch1 only
      rst_dut("B");
      cfg(1, '0, QT);
      clken = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         tick();
         if (e >= 3) begin
            if ((e - 3) % 4 == 1) chk_out($sformatf("B.e%0d", e), 1, 32767, -101);
            else chk_out($sformatf("B.e%0d", e), (e - 3) % 4, 101, 32767);
         end
      end
      // quarter-turn increment on ch0 walks the four quadrants
      rst_dut("C");
      cfg(0, QT, '0);
      clken = 1'b1;
      for (int k = 1; k <= 34; k++) begin
         tick();
         if (e >= 3) begin
            if ((e - 3) % 4 == 0) chk_out($sformatf("C.e%0d", e), 0, sq[((e - 3) / 4) % 4], cq[((e - 3) / 4) % 4]);
            else chk_out($sformatf("C.e%0d", e), (e - 3) % 4, 101, 32767);
         end
      end
      // sync on edge 11 (processing ch2): 3 in-flight samples, then restart from ch0
      rst_dut("D");
      cfg(0, QT, '0);
      cfg(1, HT, '0);
      clken = 1'b1;
      repeat (10) tick();
      sync_i = 1'b1;
      tick();
      sync_i = 1'b0;
      chk_out("D.e11", 0, -101, -32767);
      tick(); chk_out("D.e12", 1, 101, 32767);
      tick(); chk_out("D.e13", 2, 101, 32767);
      tick(); chk_out("D.e14", 0, 101, 32767);
      tick(); chk_out("D.e15", 1, 101, 32767);
      tick(); chk_out("D.e16", 2, 101, 32767);
      tick(); chk_out("D.e17", 3, 101, 32767);
      tick(); chk_out("D.e18", 0, 32767, -101);
      tick(); chk_out("D.e19", 1, -101, -32767);
      // clken gap of 5 cycles: everything frozen, sequence resumes in order
      rst_dut("E");
      cfg(0, QT, '0);
      clken = 1'b1;
      repeat (7) tick();
      chk_out("E.e7", 0, 32767, -101);
      clken = 1'b0;
      for (int k = 0; k < 5; k++) begin
         tick();
         chk_out($sformatf("E.hold%0d", k), 0, 32767, -101);
      end
      clken = 1'b1;
      for (int k = 8; k <= 15; k++) begin
         tick();
         if ((e - 3) % 4 == 0) chk_out($sformatf("E.e%0d", e), 0, sq[((e - 3) / 4) % 4], cq[((e - 3) / 4) % 4]);
         else chk_out($sformatf("E.e%0d", e), (e - 3) % 4, 101, 32767);
      end
      // cfg to ch2 on its own processing edge (edge 7): old inc QT, new inc HT
      rst_dut("F");
      cfg(2, QT, '0);
      clken = 1'b1;
      repeat (2) tick();
      chk("F.valid_e2", int'(out_valid), 0);
      repeat (3) tick();
      chk_out("F.e5", 2, 101, 32767);
      tick();
      cfg_we = 1'b1;
      cfg_ch = 2'd2;
      cfg_phi_inc = HT;
      cfg_phase_ofs = '0;
      tick();
      cfg_we = 1'b0;
      repeat (2) tick();
      chk_out("F.e9", 2, 32767, -101);
      repeat (4) tick();
      chk_out("F.e13", 2, -101, -32767);
      repeat (4) tick();
      chk_out("F.e17", 2, 101, 32767);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/nco_mc.md
# nco_mc

Multi-channel, time-division-multiplexed quadrature NCO. It is the parametrised successor of the single-channel NCO. One datapath serves NCH channels in round-robin order, one channel per enabled cycle. Each channel has its own phase increment, phase offset and accumulator. Outputs are sin/cos samples tagged with their channel number, for the downconversion and IQ mixer stages.

## Interface
- NCH, 4: number of channels; power of 2, 1..64; CHW = max(1, $clog2(NCH))
- APR, 32: phase accumulator / increment / offset width
- MPR, 16: signed output sample width
- LUT_AW, 8: quarter-wave LUT address width; phase is truncated to LUT_AW+2 bits; APR ≥ LUT_AW+2+DITHER_W
- DITHER_W, 4: dither bits added below the truncation point (used only with NCO_MC_DITHER_EN)
- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- clken  in  1  global clock enable; all state holds when low
- sync_i  in  1  synchronous phase reset of all channels
- cfg_we  in  1  write strobe for channel configuration
- cfg_ch  in  CHW  channel to configure
- cfg_phi_inc  in  APR  phase increment written on cfg_we
- cfg_phase_ofs  in  APR  phase offset written on cfg_we
- fsin_o  out  MPR  signed sine sample
- fcos_o  out  MPR  signed cosine sample
- out_ch  out  CHW  channel of the current sample
- out_valid  out  1  sample/channel outputs are meaningful

## Operation
- Reset values: acc[*], inc[*], ofs[*], ch_cnt, all pipeline registers, fsin_o, fcos_o, out_ch and out_valid are all 0.
- ch_cnt increments modulo NCH on every clken edge and wraps from NCH-1 to 0.
- Stage 1 (edge with ch_cnt=c):
  - P1 <= acc[c] + ofs[c] (mod 2^APR), plus dither if enabled.
  - acc[c] <= acc[c] + inc[c] (mod 2^APR).
  - ch1 <= c.
- Stage 2: the top LUT_AW+2 bits of P1 are split into quadrant q (2 MSBs) and address a.
  - The LUT is read at a and at ~a.
  - q and ch are registered alongside.
- Stage 3: quadrant fold, with registered outputs:
  - q0: sin = L[a], cos = L[~a]
  - q1: sin = L[~a], cos = −L[a]
  - q2: sin = −L[a], cos = −L[~a]
  - q3: sin = −L[~a], cos = L[a]
- LUT contents: L[i] = round((2^(MPR-1)−1)·sin(2π(i+0.5)/2^(LUT_AW+2))).
  - Entries are strictly positive and negation never overflows.
- cfg_we writes inc[cfg_ch] and ofs[cfg_ch] on a clk edge regardless of clken.
  - If the written channel is being processed at the same edge, that visit uses the old values.
  - The new values take effect on the next visit.
- sync_i (sampled when clken=1):
  - Clears all acc[*] and sets ch_cnt to 0 at that edge.
  - It takes precedence over the accumulator update.
  - The in-flight pipeline drains normally.
  - inc and ofs are kept.
- cfg_we and sync_i at the same edge: both take effect.

## Timing
- Latency is 3 clken edges: the sample for channel c processed at edge k appears on fsin_o/fcos_o/out_ch after edge k+2.
- out_valid rises after the 3rd clken edge following reset release and stays high until reset.
- While clken=0, outputs and out_valid hold their values.
- Throughput is one sample per clken cycle, so each channel is updated every NCH enabled cycles.
- Output frequency of channel c is inc[c]·f_clk/(NCH·2^APR).
- Asserting reset mid-operation clears everything asynchronously; the pipeline must refill (3 edges) before out_valid rises again.

## Configuration
- NCO_MC_DITHER_EN defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 0xACE1, reset to seed) advances every clken edge.
  - Its DITHER_W LSBs are zero-extended and added at P1 bit positions [APR−LUT_AW−3 −: DITHER_W].
- NCO_MC_DITHER_EN not defined: no LFSR exists, and the output is exactly the truncated phase lookup.

## Structure
- Package nco_mc_pkg holds:
  - the quadrant type
  - the LUT initialisation function
  - the LFSR seed/tap constants
  - the CHW derivation function
- Sub-module nco_mc_qlut holds the dual-read quarter-wave LUT plus the quadrant fold (stages 2–3), parametrised by MPR and LUT_AW.

## Test plan
- Reset release with all inc/ofs = 0 and clken=1 (MPR=16, LUT_AW=8):
  - out_valid rises after the 3rd edge.
  - out_ch cycles 0,1,2,3.
  - Every sample is fsin_o = +101, fcos_o = +32767.
- ch1 with ofs = 0x4000_0000 (quarter turn) → ch1 samples are fsin_o = +32767, fcos_o = −101; other channels are unchanged.
- ch0 with inc = 0x4000_0000 → successive ch0 sin samples are 101, 32767, −101, −32767, repeating every 4·NCH cycles.
- Apply sync_i mid-run with nonzero inc:
  - 3 in-flight samples emerge unchanged.
  - The next samples restart at phase 0 from ch0, matching the post-reset sequence shifted by the inc values.
- Toggle clken low for 5 cycles mid-stream → outputs, out_ch and out_valid are frozen, and the sequence resumes without skipped or duplicated channels.
- cfg_we to ch2 on the same edge that ch2 is processed → that sample uses the old inc; the next ch2 visit uses the new inc.
